// File: rtl/dac_interp.sv
// dac_interp: linear-interpolating upsampler feeding the delta-sigma DAC
// modulator. Each accepted signed sample becomes the end point of a
// straight-line ramp that starts at the previous sample and takes
// 2^OSR_LOG2 clocks, so the modulator sees small steps on every clock
// instead of a zero-order hold.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   sample_i        signed input sample (BW bits)
//   sample_valid_i  sample_i is valid
//   sample_ready_o  sample accepted at the next rising edge if valid
//   underrun_clr_i  synchronous clear of underrun_o
//   dac_o           signed interpolated output to the modulator
//   frame_o         one-cycle strobe after each frame boundary edge
//   underrun_o      sticky: a frame boundary passed with no sample
module dac_interp #(
    parameter int unsigned BW       = 16,
    parameter int unsigned OSR_LOG2 = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [BW-1:0] sample_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic                 underrun_clr_i,
    output logic signed [BW-1:0] dac_o,
    output logic                 frame_o,
    output logic                 underrun_o
);

    localparam int unsigned ACC_W = BW + OSR_LOG2 + 1;
    localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;
    localparam logic [OSR_LOG2-1:0] CNT_ONE  = OSR_LOG2'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [OSR_LOG2-1:0]   cnt_q, cnt_d;
    logic signed [BW-1:0]  cur_q, cur_d;
    logic signed [BW:0]    delta_q, delta_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                  frame_q, frame_d;
    logic                  underrun_q, underrun_d;

    logic                  ready;
    logic [ACC_W-1:0]      cur_scaled;
    logic [ACC_W-1:0]      delta_ext;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            delta_q    <= '0;
            acc_q      <= '0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            delta_q    <= delta_d;
            acc_q      <= acc_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // cur scaled by OSR, and delta sign-extended to the accumulator width.
    assign cur_scaled = {cur_q[BW-1], cur_q, {OSR_LOG2{1'b0}}};
    assign delta_ext  = {{OSR_LOG2{delta_q[BW]}}, delta_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        delta_d    = delta_q;
        acc_d      = acc_q;
        frame_d    = 1'b0;
        underrun_d = underrun_clr_i ? 1'b0 : underrun_q;

        if (ready) begin
            if (sample_valid_i) begin
                // Restart the ramp exactly at the old target so rounding
                // error never accumulates across frames.
                acc_d   = cur_scaled;
                cnt_d   = '0;
                frame_d = 1'b1;
                delta_d = {sample_i[BW-1], sample_i} - {cur_q[BW-1], cur_q};
                cur_d   = sample_i;
                state_d = RUN;
            end else if (state_q == RUN) begin
                // Underrun: hold flat at the current target; a new set
                // takes priority over a same-edge clear.
                acc_d      = cur_scaled;
                cnt_d      = '0;
                frame_d    = 1'b1;
                delta_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            acc_d = acc_q + delta_ext;
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready = (state_q == IDLE) || (cnt_q == CNT_LAST);
    end

    assign sample_ready_o = ready;
    // Dropping the low OSR_LOG2 bits is an arithmetic shift: floor(acc/OSR).
    assign dac_o          = acc_q[OSR_LOG2+BW-1:OSR_LOG2];
    assign frame_o        = frame_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_dac_interp.sv
module tb_dac_interp;

    localparam int unsigned BW       = 16;
    localparam int unsigned OSR_LOG2 = 2;

    logic                 clk;
    logic                 rst;
    logic signed [BW-1:0] sample;
    logic                 valid;
    logic                 ready;
    logic                 clr;
    logic signed [BW-1:0] dac;
    logic                 frame;
    logic                 underrun;

    int checks = 0;
    int errors = 0;

    dac_interp #(
        .BW       (BW),
        .OSR_LOG2 (OSR_LOG2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_i       (sample),
        .sample_valid_i (valid),
        .sample_ready_o (ready),
        .underrun_clr_i (clr),
        .dac_o          (dac),
        .frame_o        (frame),
        .underrun_o     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // dac, frame, ready in one call
    task automatic chk3(input string tag, input int d, input int f, input int r);
        chk({tag, ".dac"}, dac, d);
        chk({tag, ".frame"}, frame, f);
        chk({tag, ".ready"}, ready, r);
    endtask

    initial begin
        rst    = 1'b1;
        sample = '0;
        valid  = 1'b0;
        clr    = 1'b0;

        // 1. Reset / idle
        #3;
        chk3("rst", 0, 0, 1);
        chk("rst.underrun", underrun, 0);
        step();
        rst = 1'b0;
        step();
        chk3("idle0", 0, 0, 1);
        step();
        chk3("idle1", 0, 0, 1);
        chk("idle1.underrun", underrun, 0);

        // 2. First sample 400, valid held
        sample = 16'sd400;
        valid  = 1'b1;
        step(); chk3("s400.E0", 0,   1, 0);
        step(); chk3("s400.E1", 100, 0, 0);
        step(); chk3("s400.E2", 200, 0, 0);
        step(); chk3("s400.E3", 300, 0, 1);

        // 3. Follow-on -400
        sample = -16'sd400;
        step(); chk3("m400.E0", 400,  1, 0);
        step(); chk3("m400.E1", 200,  0, 0);
        step(); chk3("m400.E2", 0,    0, 0);
        step(); chk3("m400.E3", -200, 0, 1);

        // 4. Full scale: -400 -> 32767 -> -32768
        sample = 16'sd32767;
        step(); chk3("pfs.E0", -400, 1, 0);
        step(); chk3("pfs.E1", 7891, 0, 0);
        step(); chk3("pfs.E2", 16183, 0, 0);
        step(); chk3("pfs.E3", 24475, 0, 1);
        sample = -16'sd32768;
        step(); chk3("nfs.E0", 32767,  1, 0);
        step(); chk3("nfs.E1", 16383,  0, 0);
        step(); chk3("nfs.E2", -1,     0, 0);
        step(); chk3("nfs.E3", -16385, 0, 1);
        chk("nfs.underrun", underrun, 0);

        // 5. Underrun: valid low at a RUN boundary
        valid = 1'b0;
        step(); chk3("ur.F0", -32768, 1, 0); chk("ur.F0.u", underrun, 1);
        step(); chk3("ur.F1", -32768, 0, 0); chk("ur.F1.u", underrun, 1);
        step(); chk3("ur.F2", -32768, 0, 0); chk("ur.F2.u", underrun, 1);
        step(); chk3("ur.F3", -32768, 0, 1); chk("ur.F3.u", underrun, 1);
        step(); chk3("ur.F4", -32768, 1, 0); chk("ur.F4.u", underrun, 1);
        clr = 1'b1;
        step(); chk("clr.F5.u", underrun, 0);
        clr = 1'b0;
        step();
        step(); chk("ur.F7.ready", ready, 1);
        // Clear coincides with a new underrun: set must win
        clr = 1'b1;
        step(); chk("setwins.F8.u", underrun, 1); chk("setwins.F8.frame", frame, 1);
        step(); chk("clr.F9.u", underrun, 0);
        clr = 1'b0;
        step();
        step(); chk("ur.F11.ready", ready, 1);

        // 6. Reset mid-ramp: -32768 -> 400 -> -400, reset at dac=200
        sample = 16'sd400;
        valid  = 1'b1;
        step(); chk3("g.E0", -32768, 1, 0);
        step(); chk3("g.E1", -24476, 0, 0);
        step(); chk3("g.E2", -16184, 0, 0);
        step(); chk3("g.E3", -7892,  0, 1);
        sample = -16'sd400;
        step(); chk3("h.E0", 400, 1, 0);
        step(); chk3("h.E1", 200, 0, 0);
        #2;
        rst    = 1'b1;
        sample = 16'sd800;
        #1;
        chk3("async_rst", 0, 0, 1);
        chk("async_rst.underrun", underrun, 0);
        step(); chk3("in_rst0", 0, 0, 1);
        step(); chk3("in_rst1", 0, 0, 1);
        rst = 1'b0;
        step(); chk3("p800.E0", 0,   1, 0);
        step(); chk3("p800.E1", 200, 0, 0);
        step(); chk3("p800.E2", 400, 0, 0);
        step(); chk3("p800.E3", 600, 0, 1);
        valid = 1'b0;
        step(); chk3("p800.E4", 800, 1, 0);
        chk("p800.E4.u", underrun, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
